// File: rtl/l1d_mshr_req_sched_pkg.sv
// Shared L1D MSHR request payload types, scheduler id width and stall-counter helper.
package l1d_package;

  localparam int unsigned L1D_MSHR_ENTRY_NUM   = 8;
  localparam int unsigned L1D_MSHR_ID_WIDTH    = $clog2(L1D_MSHR_ENTRY_NUM);
  localparam int unsigned L1D_MSHR_STALL_CNT_W = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  way;
    logic        dirty;
  } pack_l1d_mshr_evict_req_pld;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  opcode;
  } pack_l1d_mshr_downstream_req_pld;

  typedef struct packed {
    logic [7:0] set_idx;
    logic [1:0] way;
    logic       wr;
  } pack_l1d_mshr_rw_req_pld;

  // Saturating stall counter step; clear has priority over increment.
  function automatic logic [L1D_MSHR_STALL_CNT_W-1:0] stall_cnt_next(
    input logic [L1D_MSHR_STALL_CNT_W-1:0] cnt,
    input logic                            clr,
    input logic                            stall
  );
    if (clr) return '0;
    if (stall && (cnt != '1)) return cnt + L1D_MSHR_STALL_CNT_W'(1);
    return cnt;
  endfunction

endpackage

// File: rtl/l1d_rr_arb_stage.sv
// Round-robin arbiter over ENTRY_NUM requesters feeding a one-deep registered
// output stage that carries the winning payload and its source id.
module l1d_rr_arb_stage
  import l1d_package::*;
#(
  parameter int unsigned ENTRY_NUM = L1D_MSHR_ENTRY_NUM,
  parameter int unsigned ID_W      = $clog2(ENTRY_NUM),
  parameter type         PLD_T     = logic
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ENTRY_NUM-1:0] req_vld,
  output logic [ENTRY_NUM-1:0] req_rdy,
  input  PLD_T                 req_pld [ENTRY_NUM],
  output logic                 out_vld,
  input  logic                 out_rdy,
  output PLD_T                 out_pld,
  output logic [ID_W-1:0]      out_id
);

  logic            full_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] win_c;
  logic            any_c;
  logic            acc_c;
  logic            hs_c;

  // First requester at or after ptr_q, wrapping past the last entry.
  always_comb begin
    int unsigned idx;
    win_c = '0;
    any_c = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= ENTRY_NUM) idx = idx - ENTRY_NUM;
      if (!any_c && req_vld[ID_W'(idx)]) begin
        any_c = 1'b1;
        win_c = ID_W'(idx);
      end
    end
  end

  // Stage can take a new entry when empty or draining this cycle.
  assign acc_c   = !full_q || out_rdy;
  assign hs_c    = acc_c && any_c;
  assign out_vld = full_q;

  always_comb begin
    req_rdy = '0;
    if (hs_c) req_rdy[win_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      ptr_q  <= '0;
    end else begin
      if (hs_c) begin
        full_q <= 1'b1;
        ptr_q  <= (win_c == ID_W'(ENTRY_NUM - 1)) ? '0 : win_c + ID_W'(1);
      end else if (out_rdy) begin
        full_q <= 1'b0;
      end
    end
  end

  // Payload/id are qualified by full_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (hs_c) begin
      out_pld <= req_pld[win_c];
      out_id  <= win_c;
    end
  end

endmodule

// File: rtl/l1d_mshr_req_sched.sv
// Schedules per-entry MSHR evict / downstream / rw requests onto three shared channels.
// Optional stall counters are enabled by defining L1D_MSHR_SCHED_PERF_EN.
module l1d_mshr_req_sched
  import l1d_package::*;
#(
  parameter int unsigned ENTRY_NUM = L1D_MSHR_ENTRY_NUM,
  parameter int unsigned ID_W      = $clog2(ENTRY_NUM)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ENTRY_NUM-1:0]            v_evict_req_vld,
  output logic [ENTRY_NUM-1:0]            v_evict_req_rdy,
  input  pack_l1d_mshr_evict_req_pld      v_evict_req_pld [ENTRY_NUM],
  input  logic [ENTRY_NUM-1:0]            v_ds_req_vld,
  output logic [ENTRY_NUM-1:0]            v_ds_req_rdy,
  input  pack_l1d_mshr_downstream_req_pld v_ds_req_pld [ENTRY_NUM],
  input  logic [ENTRY_NUM-1:0]            v_rw_req_vld,
  output logic [ENTRY_NUM-1:0]            v_rw_req_rdy,
  input  pack_l1d_mshr_rw_req_pld         v_rw_req_pld [ENTRY_NUM],
`ifdef L1D_MSHR_SCHED_PERF_EN
  input  logic                            perf_clr,
  output logic [L1D_MSHR_STALL_CNT_W-1:0] evict_stall_cnt,
  output logic [L1D_MSHR_STALL_CNT_W-1:0] ds_stall_cnt,
  output logic [L1D_MSHR_STALL_CNT_W-1:0] rw_stall_cnt,
`endif
  output logic                            evict_vld,
  input  logic                            evict_rdy,
  output pack_l1d_mshr_evict_req_pld      evict_pld,
  output logic [ID_W-1:0]                 evict_id,
  output logic                            ds_vld,
  input  logic                            ds_rdy,
  output pack_l1d_mshr_downstream_req_pld ds_pld,
  output logic [ID_W-1:0]                 ds_id,
  output logic                            rw_vld,
  input  logic                            rw_rdy,
  output pack_l1d_mshr_rw_req_pld         rw_pld,
  output logic [ID_W-1:0]                 rw_id
);

  l1d_rr_arb_stage #(
    .ENTRY_NUM (ENTRY_NUM),
    .ID_W      (ID_W),
    .PLD_T     (pack_l1d_mshr_evict_req_pld)
  ) u_evict_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (v_evict_req_vld),
    .req_rdy (v_evict_req_rdy),
    .req_pld (v_evict_req_pld),
    .out_vld (evict_vld),
    .out_rdy (evict_rdy),
    .out_pld (evict_pld),
    .out_id  (evict_id)
  );

  l1d_rr_arb_stage #(
    .ENTRY_NUM (ENTRY_NUM),
    .ID_W      (ID_W),
    .PLD_T     (pack_l1d_mshr_downstream_req_pld)
  ) u_ds_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (v_ds_req_vld),
    .req_rdy (v_ds_req_rdy),
    .req_pld (v_ds_req_pld),
    .out_vld (ds_vld),
    .out_rdy (ds_rdy),
    .out_pld (ds_pld),
    .out_id  (ds_id)
  );

  l1d_rr_arb_stage #(
    .ENTRY_NUM (ENTRY_NUM),
    .ID_W      (ID_W),
    .PLD_T     (pack_l1d_mshr_rw_req_pld)
  ) u_rw_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (v_rw_req_vld),
    .req_rdy (v_rw_req_rdy),
    .req_pld (v_rw_req_pld),
    .out_vld (rw_vld),
    .out_rdy (rw_rdy),
    .out_pld (rw_pld),
    .out_id  (rw_id)
  );

`ifdef L1D_MSHR_SCHED_PERF_EN
  // Cycles each channel spent holding a request the consumer did not take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evict_stall_cnt <= '0;
      ds_stall_cnt    <= '0;
      rw_stall_cnt    <= '0;
    end else begin
      evict_stall_cnt <= stall_cnt_next(evict_stall_cnt, perf_clr, evict_vld && !evict_rdy);
      ds_stall_cnt    <= stall_cnt_next(ds_stall_cnt, perf_clr, ds_vld && !ds_rdy);
      rw_stall_cnt    <= stall_cnt_next(rw_stall_cnt, perf_clr, rw_vld && !rw_rdy);
    end
  end
`endif

endmodule

// File: tb/tb_l1d_mshr_req_sched.sv
// Directed self-checking bench for l1d_mshr_req_sched (ENTRY_NUM = 8).
module tb_l1d_mshr_req_sched;
  import l1d_package::*;

  localparam int unsigned N  = L1D_MSHR_ENTRY_NUM;
  localparam int unsigned IW = L1D_MSHR_ID_WIDTH;

  logic                            clk;
  logic                            rst_n;
  logic [N-1:0]                    v_evict_req_vld;
  logic [N-1:0]                    v_evict_req_rdy;
  pack_l1d_mshr_evict_req_pld      v_evict_req_pld [N];
  logic [N-1:0]                    v_ds_req_vld;
  logic [N-1:0]                    v_ds_req_rdy;
  pack_l1d_mshr_downstream_req_pld v_ds_req_pld [N];
  logic [N-1:0]                    v_rw_req_vld;
  logic [N-1:0]                    v_rw_req_rdy;
  pack_l1d_mshr_rw_req_pld         v_rw_req_pld [N];
  logic                            evict_vld;
  logic                            evict_rdy;
  pack_l1d_mshr_evict_req_pld      evict_pld;
  logic [IW-1:0]                   evict_id;
  logic                            ds_vld;
  logic                            ds_rdy;
  pack_l1d_mshr_downstream_req_pld ds_pld;
  logic [IW-1:0]                   ds_id;
  logic                            rw_vld;
  logic                            rw_rdy;
  pack_l1d_mshr_rw_req_pld         rw_pld;
  logic [IW-1:0]                   rw_id;
`ifdef L1D_MSHR_SCHED_PERF_EN
  logic                            perf_clr;
  logic [15:0]                     evict_stall_cnt;
  logic [15:0]                     ds_stall_cnt;
  logic [15:0]                     rw_stall_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  l1d_mshr_req_sched #(.ENTRY_NUM(N), .ID_W(IW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .v_evict_req_vld (v_evict_req_vld),
    .v_evict_req_rdy (v_evict_req_rdy),
    .v_evict_req_pld (v_evict_req_pld),
    .v_ds_req_vld    (v_ds_req_vld),
    .v_ds_req_rdy    (v_ds_req_rdy),
    .v_ds_req_pld    (v_ds_req_pld),
    .v_rw_req_vld    (v_rw_req_vld),
    .v_rw_req_rdy    (v_rw_req_rdy),
    .v_rw_req_pld    (v_rw_req_pld),
`ifdef L1D_MSHR_SCHED_PERF_EN
    .perf_clr        (perf_clr),
    .evict_stall_cnt (evict_stall_cnt),
    .ds_stall_cnt    (ds_stall_cnt),
    .rw_stall_cnt    (rw_stall_cnt),
`endif
    .evict_vld       (evict_vld),
    .evict_rdy       (evict_rdy),
    .evict_pld       (evict_pld),
    .evict_id        (evict_id),
    .ds_vld          (ds_vld),
    .ds_rdy          (ds_rdy),
    .ds_pld          (ds_pld),
    .ds_id           (ds_id),
    .rw_vld          (rw_vld),
    .rw_rdy          (rw_rdy),
    .rw_pld          (rw_pld),
    .rw_id           (rw_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pack_l1d_mshr_evict_req_pld ev_pld(input int i);
    ev_pld.addr  = 32'h1000_0000 + 32'(i) * 32'h40;
    ev_pld.way   = 2'(i);
    ev_pld.dirty = 1'(i);
  endfunction

  function automatic pack_l1d_mshr_downstream_req_pld ds_pld_of(input int i);
    ds_pld_of.addr   = 32'h2000_0000 + 32'(i) * 32'h80;
    ds_pld_of.opcode = 3'(i + 1);
  endfunction

  function automatic pack_l1d_mshr_rw_req_pld rw_pld_of(input int i);
    rw_pld_of.set_idx = 8'(8'h10 + i);
    rw_pld_of.way     = 2'(i >> 1);
    rw_pld_of.wr      = 1'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_rdy;

    rst_n           = 1'b0;
    v_evict_req_vld = '0;
    v_ds_req_vld    = '0;
    v_rw_req_vld    = '0;
    evict_rdy       = 1'b0;
    ds_rdy          = 1'b0;
    rw_rdy          = 1'b0;
`ifdef L1D_MSHR_SCHED_PERF_EN
    perf_clr        = 1'b0;
`endif
    for (int i = 0; i < int'(N); i++) begin
      v_evict_req_pld[i] = ev_pld(i);
      v_ds_req_pld[i]    = ds_pld_of(i);
      v_rw_req_pld[i]    = rw_pld_of(i);
    end

    // Reset state
    #1;
    check("rst_evict_vld", 64'(evict_vld), 64'd0);
    check("rst_ds_vld", 64'(ds_vld), 64'd0);
    check("rst_rw_vld", 64'(rw_vld), 64'd0);
    check("rst_rdy", 64'({v_evict_req_rdy, v_ds_req_rdy, v_rw_req_rdy}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // rw: all entries requesting, channel always ready -> ids 0..7,0
    v_rw_req_vld = 8'hFF;
    rw_rdy       = 1'b1;
    #1;
    check("rr_first_rdy", 64'(v_rw_req_rdy), 64'h01);
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("rr_vld_%0d", k), 64'(rw_vld), 64'd1);
      check($sformatf("rr_id_%0d", k), 64'(rw_id), 64'(k % 8));
      check($sformatf("rr_pld_%0d", k), 64'(rw_pld), 64'(rw_pld_of(k % 8)));
      exp_rdy = '0;
      exp_rdy[(k + 1) % 8] = 1'b1;
      check($sformatf("rr_rdy_%0d", k), 64'(v_rw_req_rdy), 64'(exp_rdy));
    end
    v_rw_req_vld = '0;
    tick();
    check("rr_drain_vld", 64'(rw_vld), 64'd0);

    // evict: entries 2 and 5, channel stalled for 4 cycles
    v_evict_req_vld = 8'h24;
    #1;
    check("ev_first_rdy", 64'(v_evict_req_rdy), 64'h04);
    tick();
    v_evict_req_vld = 8'h20;
    #1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("ev_stall_vld_%0d", s), 64'(evict_vld), 64'd1);
      check($sformatf("ev_stall_id_%0d", s), 64'(evict_id), 64'd2);
      check($sformatf("ev_stall_pld_%0d", s), 64'(evict_pld), 64'(ev_pld(2)));
      check($sformatf("ev_stall_rdy_%0d", s), 64'(v_evict_req_rdy), 64'd0);
      if (s < 3) tick();
    end
    evict_rdy = 1'b1;
    #1;
    check("ev_drain_rdy", 64'(v_evict_req_rdy), 64'h20);
    tick();
    v_evict_req_vld = '0;
    check("ev_next_vld", 64'(evict_vld), 64'd1);
    check("ev_next_id", 64'(evict_id), 64'd5);
    check("ev_next_pld", 64'(evict_pld), 64'(ev_pld(5)));
    tick();
    check("ev_empty_vld", 64'(evict_vld), 64'd0);

    // ds: walk pointer to 7, sole requester 7, then wrap to entry 0 first
    ds_rdy       = 1'b1;
    v_ds_req_vld = 8'h40;
    tick();
    check("ds_id6", 64'(ds_id), 64'd6);
    v_ds_req_vld = 8'h80;
    #1;
    check("ds_rdy7", 64'(v_ds_req_rdy), 64'h80);
    tick();
    check("ds_id7", 64'(ds_id), 64'd7);
    check("ds_pld7", 64'(ds_pld), 64'(ds_pld_of(7)));
    v_ds_req_vld = 8'h81;
    #1;
    check("ds_wrap_rdy", 64'(v_ds_req_rdy), 64'h01);
    tick();
    check("ds_id0", 64'(ds_id), 64'd0);
    check("ds_rdy7_again", 64'(v_ds_req_rdy), 64'h80);
    v_ds_req_vld = 8'h80;
    tick();
    check("ds_id7_again", 64'(ds_id), 64'd7);
    v_ds_req_vld = '0;
    tick();
    check("ds_empty_vld", 64'(ds_vld), 64'd0);

    // rw: entry 3 pulses vld while stage full and stalled (rw ptr = 1)
    rw_rdy       = 1'b0;
    v_rw_req_vld = 8'h01;
    tick();
    check("drop_load_id", 64'(rw_id), 64'd0);
    v_rw_req_vld = 8'h08;
    #1;
    check("drop_rdy", 64'(v_rw_req_rdy), 64'd0);
    tick();
    v_rw_req_vld = '0;
    check("drop_hold_vld", 64'(rw_vld), 64'd1);
    check("drop_hold_id", 64'(rw_id), 64'd0);
    rw_rdy = 1'b1;
    tick();
    check("drop_drain_vld", 64'(rw_vld), 64'd0);
    v_rw_req_vld = 8'h03;
    #1;
    check("drop_ptr_rdy", 64'(v_rw_req_rdy), 64'h02);
    tick();
    v_rw_req_vld = '0;
    check("drop_next_id", 64'(rw_id), 64'd1);
    tick();

    // All three classes at once: evict 1, ds 4, rw 6
    v_evict_req_vld = 8'h02;
    v_ds_req_vld    = 8'h10;
    v_rw_req_vld    = 8'h40;
    tick();
    v_evict_req_vld = '0;
    v_ds_req_vld    = '0;
    v_rw_req_vld    = '0;
    check("sim_vld", 64'({evict_vld, ds_vld, rw_vld}), 64'h7);
    check("sim_evict_id", 64'(evict_id), 64'd1);
    check("sim_ds_id", 64'(ds_id), 64'd4);
    check("sim_rw_id", 64'(rw_id), 64'd6);
    check("sim_ds_pld", 64'(ds_pld), 64'(ds_pld_of(4)));
    tick();
    check("sim_empty", 64'({evict_vld, ds_vld, rw_vld}), 64'h0);

    // Mid-operation reset clears the stage and the pointer (rw ptr = 7 now)
    rw_rdy       = 1'b0;
    v_rw_req_vld = 8'h01;
    tick();
    v_rw_req_vld = '0;
    check("mrst_loaded", 64'(rw_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_vld", 64'(rw_vld), 64'd0);
    tick();
    rst_n        = 1'b1;
    v_rw_req_vld = 8'h03;
    #1;
    check("mrst_ptr_rdy", 64'(v_rw_req_rdy), 64'h01);
    v_rw_req_vld = '0;
    tick();

`ifdef L1D_MSHR_SCHED_PERF_EN
    // Stall counter saturation and clear
    rw_rdy       = 1'b0;
    v_rw_req_vld = 8'h04;
    tick();
    v_rw_req_vld = '0;
    repeat (70000) tick();
    check("perf_sat", 64'(rw_stall_cnt), 64'hFFFF);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf_clr", 64'(rw_stall_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
